// File: rtl/rdma_arb_pkg.sv
// Shared constants, word typedefs and the round-robin search helper used by
// the SQ arbiter and its bench.
package rdma_arb_pkg;

  localparam int VFID_BITS    = 4;
  localparam int VFID_LSB     = 16;
  localparam int ACK_VFID_LSB = 8;
  localparam int DEF_SQ_BITS  = 256;
  localparam int DEF_ACK_BITS = 32;

  typedef logic [DEF_SQ_BITS-1:0]  sq_req_t;
  typedef logic [DEF_ACK_BITS-1:0] ack_t;

  // Returns {found, index} of the first set bit at or after ptr, wrapping at n.
  function automatic logic [4:0] rr_pick(input logic [15:0] req,
                                         input logic [3:0]  ptr,
                                         input int          n);
    logic [4:0] r;
    int         idx;
    r = '0;
    for (int k = n - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % n;
      if (req[idx[3:0]]) r = {1'b1, idx[3:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among req, pointer advances past each
// winner whenever en allows a grant.
module rr_arbiter
  import rdma_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [4:0]    pick;

  always_comb begin
    pick  = rr_pick(16'(req), 4'(ptr), N);
    grant = '0;
    for (int i = 0; i < N; i++)
      grant[i] = en && pick[4] && (pick[3:0] == 4'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (en && pick[4])
      ptr <= PW'((int'(pick[3:0]) + 1) % N);
  end

endmodule

// File: rtl/rdma_sq_arbiter.sv
// Shares one RDMA SQ channel between N_REGIONS with credit-gated round robin
// and routes ACKs back by vfid. Optional stats: RDMA_SQ_ARB_STATS_EN.
module rdma_sq_arbiter
  import rdma_arb_pkg::*;
#(
  parameter int N_REGIONS       = 4,
  parameter int SQ_BITS         = DEF_SQ_BITS,
  parameter int ACK_BITS        = DEF_ACK_BITS,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [N_REGIONS-1:0]         s_sq_valid,
  output logic [N_REGIONS-1:0]         s_sq_ready,
  input  logic [N_REGIONS*SQ_BITS-1:0] s_sq_data,
  output logic                         m_sq_valid,
  input  logic                         m_sq_ready,
  output logic [SQ_BITS-1:0]           m_sq_data,
  input  logic                         s_ack_valid,
  output logic                         s_ack_ready,
  input  logic [ACK_BITS-1:0]          s_ack_data,
  output logic [N_REGIONS-1:0]         m_ack_valid,
  input  logic [N_REGIONS-1:0]         m_ack_ready,
  output logic [ACK_BITS-1:0]          m_ack_data,
  output logic                         err_ack,
  output logic                         outstanding_any
`ifdef RDMA_SQ_ARB_STATS_EN
  ,
  input  logic [((N_REGIONS > 1) ? $clog2(N_REGIONS) : 1)-1:0] stat_sel,
  output logic [31:0]                  stat_cnt
`endif
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic                 run;
  logic                 slot_free;
  logic [N_REGIONS-1:0] eligible;
  logic [N_REGIONS-1:0] grant;
  logic [VFID_BITS-1:0] gidx;
  logic [SQ_BITS-1:0]   gword;
  logic [CW-1:0]        cnt [N_REGIONS];

  logic [VFID_BITS-1:0] ack_vfid;
  logic                 ack_vfid_ok;
  logic                 ack_drain;
  logic                 ack_hs;
  logic [N_REGIONS-1:0] ack_onehot;
  logic [N_REGIONS-1:0] inc;
  logic [N_REGIONS-1:0] dec;
  logic                 underflow;

  // Holds off all handshakes until the first clock after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) run <= 1'b0;
    else          run <= 1'b1;
  end

  assign slot_free = !m_sq_valid || m_sq_ready;

  always_comb begin
    for (int i = 0; i < N_REGIONS; i++)
      eligible[i] = s_sq_valid[i] && (cnt[i] < CW'(MAX_OUTSTANDING));
  end

  rr_arbiter #(.N(N_REGIONS)) u_rr (
    .clk   (aclk),
    .rst_n (aresetn),
    .req   (eligible),
    .en    (run && slot_free),
    .grant (grant)
  );

  assign s_sq_ready = grant;

  always_comb begin
    gidx  = '0;
    gword = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (grant[i]) begin
        gidx  = VFID_BITS'(i);
        gword = s_sq_data[i*SQ_BITS +: SQ_BITS];
      end
    end
    gword[VFID_LSB +: VFID_BITS] = gidx;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_sq_valid <= 1'b0;
      m_sq_data  <= '0;
    end else if (slot_free) begin
      m_sq_valid <= |grant;
      if (|grant) m_sq_data <= gword;
    end
  end

  assign ack_vfid    = s_ack_data[ACK_VFID_LSB +: VFID_BITS];
  assign ack_vfid_ok = int'(ack_vfid) < N_REGIONS;
  assign ack_drain   = |(m_ack_valid & m_ack_ready);
  assign s_ack_ready = run && (!(|m_ack_valid) || ack_drain);
  assign ack_hs      = s_ack_valid && s_ack_ready;

  always_comb begin
    underflow = 1'b0;
    for (int i = 0; i < N_REGIONS; i++) begin
      ack_onehot[i] = ack_vfid_ok && (ack_vfid == VFID_BITS'(i));
      inc[i]        = s_sq_valid[i] && grant[i];
      dec[i]        = ack_hs && ack_onehot[i];
      if (dec[i] && !inc[i] && (cnt[i] == '0)) underflow = 1'b1;
    end
  end

  // Illegal-vfid ACKs are swallowed here: no data load, no region valid.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_ack_valid <= '0;
      m_ack_data  <= '0;
    end else if (ack_hs) begin
      m_ack_valid <= ack_onehot;
      if (ack_vfid_ok) m_ack_data <= s_ack_data;
    end else if (ack_drain) begin
      m_ack_valid <= '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_REGIONS; i++) cnt[i] <= '0;
      err_ack <= 1'b0;
    end else begin
      for (int i = 0; i < N_REGIONS; i++) begin
        if (inc[i] && !dec[i])
          cnt[i] <= cnt[i] + CW'(1);
        else if (dec[i] && !inc[i] && (cnt[i] != '0))
          cnt[i] <= cnt[i] - CW'(1);
      end
      if ((ack_hs && !ack_vfid_ok) || underflow) err_ack <= 1'b1;
    end
  end

  always_comb begin
    outstanding_any = 1'b0;
    for (int i = 0; i < N_REGIONS; i++)
      if (cnt[i] != '0) outstanding_any = 1'b1;
  end

`ifdef RDMA_SQ_ARB_STATS_EN
  logic [31:0] issued [N_REGIONS];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_REGIONS; i++) issued[i] <= '0;
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REGIONS; i++)
        if (grant[i]) issued[i] <= issued[i] + 32'd1;
      stat_cnt <= issued[stat_sel];
    end
  end
`endif

endmodule

// File: tb/tb_rdma_sq_arbiter.sv
// Scoreboard bench for rdma_sq_arbiter: expected SQ words are queued at grant
// time and compared by a monitor when the crossing side accepts them.
module tb_rdma_sq_arbiter;
  import rdma_arb_pkg::*;

  localparam int N    = 4;
  localparam int SQB  = 256;
  localparam int AB   = 32;
  localparam int MAXO = 32;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [N-1:0]    s_sq_valid;
  logic [N-1:0]    s_sq_ready;
  logic [N*SQB-1:0] s_sq_data;
  logic            m_sq_valid;
  logic            m_sq_ready;
  logic [SQB-1:0]  m_sq_data;
  logic            s_ack_valid;
  logic            s_ack_ready;
  logic [AB-1:0]   s_ack_data;
  logic [N-1:0]    m_ack_valid;
  logic [N-1:0]    m_ack_ready;
  logic [AB-1:0]   m_ack_data;
  logic            err_ack;
  logic            outstanding_any;

  int      chk_cnt  = 0;
  int      pass_cnt = 0;
  sq_req_t sb[$];

  rdma_sq_arbiter #(
    .N_REGIONS(N), .SQ_BITS(SQB), .ACK_BITS(AB), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_sq_valid(s_sq_valid), .s_sq_ready(s_sq_ready), .s_sq_data(s_sq_data),
    .m_sq_valid(m_sq_valid), .m_sq_ready(m_sq_ready), .m_sq_data(m_sq_data),
    .s_ack_valid(s_ack_valid), .s_ack_ready(s_ack_ready), .s_ack_data(s_ack_data),
    .m_ack_valid(m_ack_valid), .m_ack_ready(m_ack_ready), .m_ack_data(m_ack_data),
    .err_ack(err_ack), .outstanding_any(outstanding_any)
  );

  always #5 aclk = ~aclk;

  function automatic sq_req_t sq_word(input int r, input int n);
    logic [31:0] v;
    v = 32'hC0DE_0000 + 32'(r) * 32'h1000 + 32'(n);
    return {8{v}};
  endfunction

  function automatic sq_req_t exp_word(input int r, input int n);
    sq_req_t w;
    w = sq_word(r, n);
    w[VFID_LSB +: VFID_BITS] = 4'(r);
    return w;
  endfunction

  function automatic ack_t mk_ack(input int v, input int tag);
    ack_t a;
    a = 32'hA500_0000 | (32'(tag) << 16);
    a[ACK_VFID_LSB +: VFID_BITS] = 4'(v);
    return a;
  endfunction

  task automatic set_data(input int r, input int n);
    s_sq_data[r*SQB +: SQB] = sq_word(r, n);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn     = 1'b0;
    s_sq_valid  = '0;
    s_sq_data   = '0;
    m_sq_ready  = 1'b0;
    s_ack_valid = 1'b0;
    s_ack_data  = '0;
    m_ack_ready = '0;
    sb.delete();
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
    tick();
  endtask

  task automatic drain();
    s_sq_valid = '0;
    m_sq_ready = 1'b1;
    repeat (2) tick();
  endtask

  // Pops one expected word per accepted output beat.
  always @(negedge aclk) begin
    sq_req_t e;
    if (aresetn && m_sq_valid && m_sq_ready) begin
      chk_cnt++;
      if (sb.size() == 0) begin
        $display("[TB] FAIL sq_sb_underrun got=%h exp=none", m_sq_data);
      end else begin
        e = sb.pop_front();
        if (m_sq_data !== e) $display("[TB] FAIL sq_data got=%h exp=%h", m_sq_data, e);
        else pass_cnt++;
      end
    end
  end

  task automatic test_reset();
    aresetn     = 1'b1;
    s_sq_valid  = '1;
    s_sq_data   = '1;
    m_sq_ready  = 1'b1;
    s_ack_valid = 1'b1;
    s_ack_data  = mk_ack(1, 0);
    m_ack_ready = '1;
    #2 aresetn = 1'b0;
    #3;
    chk_cnt++; if ({m_sq_valid, s_sq_ready, s_ack_ready, m_ack_valid, err_ack, outstanding_any} !== 12'd0)
      $display("[TB] FAIL reset_ctrl got=%b exp=0", {m_sq_valid, s_sq_ready, s_ack_ready, m_ack_valid, err_ack, outstanding_any});
    else pass_cnt++;
    chk_cnt++; if ((m_sq_data !== '0) || (m_ack_data !== '0))
      $display("[TB] FAIL reset_data got=%h/%h exp=0", m_sq_data, m_ack_data);
    else pass_cnt++;
    @(negedge aclk);
    chk_cnt++; if (s_sq_ready !== 4'b0000) $display("[TB] FAIL reset_ready_clk got=%b exp=0000", s_sq_ready);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    set_data(0, 0);
    set_data(2, 0);
    s_sq_valid = 4'b0101;
    m_sq_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      @(negedge aclk);
      chk_cnt++; if (s_sq_ready !== exp_g) $display("[TB] FAIL rr_grant k=%0d got=%b exp=%b", k, s_sq_ready, exp_g);
      else pass_cnt++;
      chk_cnt++; if (m_sq_valid !== ((k > 0) ? 1'b1 : 1'b0)) $display("[TB] FAIL rr_valid k=%0d got=%b", k, m_sq_valid);
      else pass_cnt++;
      sb.push_back(exp_word((k % 2 == 0) ? 0 : 2, 0));
      tick();
    end
    drain();
    chk_cnt++; if (sb.size() != 0 || m_sq_valid !== 1'b0) $display("[TB] FAIL rr_drain got=%0d/%b exp=0/0", sb.size(), m_sq_valid);
    else pass_cnt++;
  endtask

  task automatic test_credit_stall();
    do_reset();
    set_data(1, 0);
    set_data(3, 0);
    s_sq_valid  = 4'b0010;
    m_sq_ready  = 1'b1;
    m_ack_ready = '1;
    for (int k = 0; k < MAXO; k++) begin
      @(negedge aclk);
      chk_cnt++; if (s_sq_ready !== 4'b0010) $display("[TB] FAIL credit_fill k=%0d got=%b exp=0010", k, s_sq_ready);
      else pass_cnt++;
      sb.push_back(exp_word(1, 0));
      tick();
    end
    s_sq_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk_cnt++; if (s_sq_ready !== 4'b1000) $display("[TB] FAIL credit_stall k=%0d got=%b exp=1000", k, s_sq_ready);
      else pass_cnt++;
      sb.push_back(exp_word(3, 0));
      tick();
    end
    s_ack_valid = 1'b1;
    s_ack_data  = mk_ack(1, 1);
    @(negedge aclk);
    chk_cnt++; if ({s_ack_ready, s_sq_ready} !== 5'b1_1000) $display("[TB] FAIL credit_ack_cycle got=%b exp=11000", {s_ack_ready, s_sq_ready});
    else pass_cnt++;
    sb.push_back(exp_word(3, 0));
    tick();
    s_ack_valid = 1'b0;
    @(negedge aclk);
    chk_cnt++; if (s_sq_ready !== 4'b0010) $display("[TB] FAIL credit_return got=%b exp=0010", s_sq_ready);
    else pass_cnt++;
    chk_cnt++; if (m_ack_valid !== 4'b0010 || m_ack_data !== mk_ack(1, 1))
      $display("[TB] FAIL credit_ack_route got=%b/%h exp=0010/%h", m_ack_valid, m_ack_data, mk_ack(1, 1));
    else pass_cnt++;
    sb.push_back(exp_word(1, 0));
    tick();
    drain();
    chk_cnt++; if (sb.size() != 0) $display("[TB] FAIL credit_sb_left got=%0d exp=0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_data(0, 0);
    s_sq_valid = 4'b0001;
    m_sq_ready = 1'b0;
    @(negedge aclk);
    chk_cnt++; if (s_sq_ready !== 4'b0001) $display("[TB] FAIL bp_first got=%b exp=0001", s_sq_ready);
    else pass_cnt++;
    sb.push_back(exp_word(0, 0));
    tick();
    set_data(0, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk_cnt++; if (s_sq_ready !== 4'b0000) $display("[TB] FAIL bp_ready k=%0d got=%b exp=0000", k, s_sq_ready);
      else pass_cnt++;
      chk_cnt++; if (m_sq_valid !== 1'b1 || m_sq_data !== exp_word(0, 0))
        $display("[TB] FAIL bp_hold k=%0d got=%b/%h exp=1/%h", k, m_sq_valid, m_sq_data, exp_word(0, 0));
      else pass_cnt++;
      tick();
    end
    m_sq_ready = 1'b1;
    @(negedge aclk);
    chk_cnt++; if (s_sq_ready !== 4'b0001) $display("[TB] FAIL bp_release got=%b exp=0001", s_sq_ready);
    else pass_cnt++;
    sb.push_back(exp_word(0, 1));
    tick();
    drain();
    chk_cnt++; if (sb.size() != 0) $display("[TB] FAIL bp_sb_left got=%0d exp=0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_ack_path();
    do_reset();
    set_data(0, 0);
    set_data(2, 0);
    s_sq_valid = 4'b0101;
    m_sq_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      chk_cnt++; if (s_sq_ready !== ((k == 0) ? 4'b0001 : 4'b0100)) $display("[TB] FAIL ack_setup k=%0d got=%b", k, s_sq_ready);
      else pass_cnt++;
      sb.push_back(exp_word((k == 0) ? 0 : 2, 0));
      tick();
    end
    s_sq_valid  = '0;
    s_ack_valid = 1'b1;
    s_ack_data  = mk_ack(2, 1);
    @(negedge aclk);
    chk_cnt++; if (s_ack_ready !== 1'b1) $display("[TB] FAIL ack_accept1 got=%b exp=1", s_ack_ready);
    else pass_cnt++;
    tick();
    s_ack_data = mk_ack(0, 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk_cnt++; if (m_ack_valid !== 4'b0100 || m_ack_data !== mk_ack(2, 1))
        $display("[TB] FAIL ack_hold k=%0d got=%b/%h exp=0100/%h", k, m_ack_valid, m_ack_data, mk_ack(2, 1));
      else pass_cnt++;
      chk_cnt++; if (s_ack_ready !== 1'b0) $display("[TB] FAIL ack_block k=%0d got=%b exp=0", k, s_ack_ready);
      else pass_cnt++;
      tick();
    end
    m_ack_ready = 4'b0100;
    @(negedge aclk);
    chk_cnt++; if (s_ack_ready !== 1'b1) $display("[TB] FAIL ack_drain_ready got=%b exp=1", s_ack_ready);
    else pass_cnt++;
    tick();
    s_ack_valid = 1'b0;
    m_ack_ready = '1;
    @(negedge aclk);
    chk_cnt++; if (m_ack_valid !== 4'b0001 || m_ack_data !== mk_ack(0, 2))
      $display("[TB] FAIL ack_second got=%b/%h exp=0001/%h", m_ack_valid, m_ack_data, mk_ack(0, 2));
    else pass_cnt++;
    tick();
    @(negedge aclk);
    chk_cnt++; if ({m_ack_valid, err_ack, outstanding_any} !== 6'd0)
      $display("[TB] FAIL ack_idle got=%b exp=000000", {m_ack_valid, err_ack, outstanding_any});
    else pass_cnt++;
    tick();
    s_ack_valid = 1'b1;
    s_ack_data  = mk_ack(9, 3);
    @(negedge aclk);
    chk_cnt++; if (s_ack_ready !== 1'b1) $display("[TB] FAIL ack_bad_accept got=%b exp=1", s_ack_ready);
    else pass_cnt++;
    tick();
    s_ack_valid = 1'b0;
    @(negedge aclk);
    chk_cnt++; if (m_ack_valid !== 4'b0000 || err_ack !== 1'b1)
      $display("[TB] FAIL ack_bad_drop got=%b/%b exp=0000/1", m_ack_valid, err_ack);
    else pass_cnt++;
    chk_cnt++; if (sb.size() != 0) $display("[TB] FAIL ack_sb_left got=%0d exp=0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_credit_corner();
    do_reset();
    set_data(0, 0);
    s_sq_valid  = 4'b0001;
    m_sq_ready  = 1'b1;
    m_ack_ready = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk_cnt++; if (s_sq_ready !== 4'b0001) $display("[TB] FAIL corner_fill k=%0d got=%b exp=0001", k, s_sq_ready);
      else pass_cnt++;
      sb.push_back(exp_word(0, 0));
      tick();
    end
    s_ack_valid = 1'b1;
    s_ack_data  = mk_ack(0, 4);
    @(negedge aclk);
    chk_cnt++; if ({s_ack_ready, s_sq_ready} !== 5'b1_0001) $display("[TB] FAIL corner_both got=%b exp=10001", {s_ack_ready, s_sq_ready});
    else pass_cnt++;
    sb.push_back(exp_word(0, 0));
    tick();
    s_sq_valid  = '0;
    s_ack_valid = 1'b0;
    @(negedge aclk);
    chk_cnt++; if (dut.cnt[0] !== 6'd5 || err_ack !== 1'b0) $display("[TB] FAIL corner_same_cycle got=%0d/%b exp=5/0", dut.cnt[0], err_ack);
    else pass_cnt++;
    tick();
    s_ack_valid = 1'b1;
    s_ack_data  = mk_ack(1, 5);
    @(negedge aclk);
    chk_cnt++; if (s_ack_ready !== 1'b1) $display("[TB] FAIL corner_uf_accept got=%b exp=1", s_ack_ready);
    else pass_cnt++;
    tick();
    s_ack_valid = 1'b0;
    @(negedge aclk);
    chk_cnt++; if (dut.cnt[1] !== 6'd0 || err_ack !== 1'b1) $display("[TB] FAIL corner_underflow got=%0d/%b exp=0/1", dut.cnt[1], err_ack);
    else pass_cnt++;
    tick();
    chk_cnt++; if (sb.size() != 0) $display("[TB] FAIL corner_sb_left got=%0d exp=0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_data(0, 0);
    set_data(2, 0);
    s_sq_valid = 4'b0101;
    m_sq_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      sb.push_back(exp_word((k % 2 == 0) ? 0 : 2, 0));
      tick();
    end
    chk_cnt++; if (m_sq_valid !== 1'b1) $display("[TB] FAIL mid_pre_valid got=%b exp=1", m_sq_valid);
    else pass_cnt++;
    aresetn = 1'b0;
    #1;
    chk_cnt++; if ({m_sq_valid, s_sq_ready, outstanding_any} !== 6'd0 || m_sq_data !== '0)
      $display("[TB] FAIL mid_reset_out got=%b/%h exp=0", {m_sq_valid, s_sq_ready, outstanding_any}, m_sq_data);
    else pass_cnt++;
    chk_cnt++; if (dut.cnt[0] !== 6'd0 || dut.cnt[2] !== 6'd0 || dut.u_rr.ptr !== 2'd0)
      $display("[TB] FAIL mid_reset_state got=%0d/%0d/%0d exp=0/0/0", dut.cnt[0], dut.cnt[2], dut.u_rr.ptr);
    else pass_cnt++;
    sb.delete();
    @(posedge aclk);
    #2 aresetn = 1'b1;
    tick();
    @(negedge aclk);
    chk_cnt++; if (s_sq_ready !== 4'b0001) $display("[TB] FAIL mid_resume got=%b exp=0001", s_sq_ready);
    else pass_cnt++;
    sb.push_back(exp_word(0, 0));
    tick();
    drain();
    chk_cnt++; if (sb.size() != 0) $display("[TB] FAIL mid_sb_left got=%0d exp=0", sb.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_credit_stall();
    test_backpressure();
    test_ack_path();
    test_credit_corner();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rdma_sq_arbiter.md
Name: rdma_sq_arbiter

Overview:
- Shares the single RDMA send-queue (SQ) request channel between N_REGIONS user regions (vFPGAs) in the user clock domain, upstream of the nclk crossing.
- Round-robin arbitration among eligible regions, gated by per-region outstanding-request credits.
- Tags each forwarded request with its source region and routes returning ACKs back to the owning region, returning the credit.

Parameters:
- N_REGIONS, 4, number of requesting regions (1..16).
- SQ_BITS, 256, SQ request word width.
- ACK_BITS, 32, ACK word width.
- MAX_OUTSTANDING, 32, per-region credit limit (power of two, ≥2).

Ports:
- aclk  in  1  user clock.
- aresetn  in  1  asynchronous active-low reset.
- s_sq_valid  in  N_REGIONS  per-region request valid.
- s_sq_ready  out  N_REGIONS  per-region request ready.
- s_sq_data  in  N_REGIONS*SQ_BITS  request words, region i at [i*SQ_BITS +: SQ_BITS].
- m_sq_valid  out  1  arbitrated request valid (to crossing).
- m_sq_ready  in  1  crossing ready.
- m_sq_data  out  SQ_BITS  arbitrated request, vfid field overwritten.
- s_ack_valid  in  1  ACK from crossing.
- s_ack_ready  out  1  ACK ready.
- s_ack_data  in  ACK_BITS  ACK word.
- m_ack_valid  out  N_REGIONS  per-region ACK valid (one-hot).
- m_ack_ready  in  N_REGIONS  per-region ACK ready.
- m_ack_data  out  ACK_BITS  ACK word (shared across regions).
- err_ack  out  1  sticky: ACK with illegal vfid, or credit underflow.
- outstanding_any  out  1  OR of all credit counters being non-zero.

Behaviour:
- Reset (async assert, sync release): all m_*_valid = 0, s_sq_ready = 0, s_ack_ready = 0, err_ack = 0, data registers = 0, RR pointer = 0, all counters = 0.
- Eligibility: region i is eligible iff s_sq_valid[i] and cnt[i] < MAX_OUTSTANDING.
- Arbitration: each cycle, the first eligible region at or after rr_ptr (wrapping) is granted, provided the output slot is empty or draining (m_sq_valid & m_sq_ready).
  - s_sq_ready is one-hot on the granted region; all zeros if none.
  - On grant i: rr_ptr <= (i+1) mod N_REGIONS.
- Output register: single slot. m_sq_valid rises the cycle after grant (latency 1). It holds stable until m_sq_ready; back-to-back throughput is 1 per cycle.
  - m_sq_data = s_sq_data[i] with bits [VFID_LSB +: VFID_BITS] replaced by i.
- Credits:
  - cnt[i] increments on the s_sq handshake of region i.
  - cnt[i] decrements on the s_ack handshake tagged i.
  - Both in the same cycle: unchanged.
  - Decrement at 0: saturate at 0, set err_ack.
  - A region at MAX_OUTSTANDING stalls without affecting the others.
- ACK path: single-slot register.
  - s_ack_ready = !ack_full | (m_ack_valid & m_ack_ready) for the target region.
  - vfid = s_ack_data[ACK_VFID_LSB +: VFID_BITS].
  - vfid ≥ N_REGIONS: the ACK is accepted and dropped (no m_ack_valid, no credit change) and err_ack is set.
  - Valid ACK: m_ack_valid[vfid] is asserted the next cycle and held until m_ack_ready[vfid].
- Data stability: m_sq_data and m_ack_data do not change while valid is high and not accepted.

Optional Feature:
- RDMA_SQ_ARB_STATS_EN defined:
  - Adds input stat_sel (clog2(N_REGIONS) bits) and output stat_cnt (32 bits).
  - stat_cnt is a registered read of the per-region issued-request counter. It is 32-bit, wraps, reset 0, and increments on each grant.
- Undefined: the ports are absent and no counters are synthesized.

Decomposition:
- Package rdma_arb_pkg holds:
  - VFID_BITS=4, VFID_LSB (SQ vfid position), ACK_VFID_LSB.
  - Typedefs sq_req_t (SQ_BITS packed) and ack_t (ACK_BITS packed).
  - A function for round-robin first-set search from a pointer.
- One sub-module, rr_arbiter: parameter N, inputs req/en, outputs one-hot grant, with an internal pointer. Credit counters and the ACK path stay in the top module.

Test Plan:
- Regions 0 and 2 request continuously, m_sq_ready=1 → grants alternate 0,2,0,2; vfid field = 0,2,0,2; one request per cycle after 1-cycle latency.
- Region 1 issues 32 requests with no ACKs → 33rd stalls (s_sq_ready[1]=0) while region 3 is still granted; one ACK vfid=1 → region 1 is granted next eligible cycle.
- m_sq_ready held low 5 cycles with a request pending → m_sq_data stable, no further s_sq_ready; release → accepted, next grant issued the same cycle.
- ACK vfid=2 while m_ack_ready[2]=0 for 3 cycles → m_ack_valid[2] held, s_ack_ready=0 for the next ACK; ACK vfid=9 (N=4) → dropped, err_ack=1.
- Same-cycle issue and ACK for region 0 with cnt=5 → cnt stays 5. ACK to region with cnt=0 → cnt 0, err_ack=1.
- aresetn asserted mid-burst with m_sq_valid=1 → outputs drop to 0 immediately, counters and rr_ptr return to 0; after release, arbitration resumes from region 0.
